// File: rtl/fir_pkg.sv
// Shared definitions for the fixed-coefficient streaming FIR filter:
// default geometry, output width rule, default taps and signed typedefs.
package fir_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_COEFF_WIDTH = 8;
    localparam int DEF_TAPS        = 4;

    // Two guard bits on top of the full product width keep a 4-tap sum exact.
    function automatic int OUT_W(input int dw, input int cw);
        return dw + cw + 2;
    endfunction

    localparam int DEF_OUT_W = DEF_DATA_WIDTH + DEF_COEFF_WIDTH + 2;

    // Slice [k*CW +: CW] holds h[k]; default h = [1,2,3,4].
    localparam logic [DEF_TAPS*DEF_COEFF_WIDTH-1:0] DEFAULT_COEFFS =
        {8'sd4, 8'sd3, 8'sd2, 8'sd1};

    typedef logic signed [DEF_DATA_WIDTH-1:0]  sample_t;
    typedef logic signed [DEF_COEFF_WIDTH-1:0] coeff_t;
    typedef logic signed [DEF_OUT_W-1:0]       acc_t;

endpackage

// File: rtl/fir_tap_mac.sv
// One FIR tap: signed sample times a fixed signed coefficient, with the
// full-precision product sign-extended to the accumulator width.
module fir_tap_mac
    import fir_pkg::*;
#(
    parameter int                             DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int                             COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter logic signed [COEFF_WIDTH-1:0]  COEFF       = '0
) (
    input  logic signed [DATA_WIDTH-1:0]                        sample_i,
    output logic signed [OUT_W(DATA_WIDTH, COEFF_WIDTH)-1:0]    product_o
);

    localparam int PW = DATA_WIDTH + COEFF_WIDTH;

    localparam logic signed [PW-1:0] COEFF_EXT =
        {{DATA_WIDTH{COEFF[COEFF_WIDTH-1]}}, COEFF};

    logic signed [PW-1:0] sample_ext;
    logic signed [PW-1:0] prod;

    // Both operands are widened to the product width first so the multiply
    // is exact in PW bits and needs no further truncation.
    assign sample_ext = {{COEFF_WIDTH{sample_i[DATA_WIDTH-1]}}, sample_i};
    assign prod       = sample_ext * COEFF_EXT;
    assign product_o  = {{2{prod[PW-1]}}, prod};

endmodule

// File: rtl/fir_filter.sv
// Direct-form TAPS-tap signed FIR with a valid strobe and no backpressure.
// One registered output per accepted sample, one cycle after acceptance.
module fir_filter
    import fir_pkg::*;
#(
    parameter int                               DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int                               COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter int                               TAPS        = DEF_TAPS,
    parameter logic [TAPS*COEFF_WIDTH-1:0]      COEFFS      = DEFAULT_COEFFS
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic signed [DATA_WIDTH-1:0]                        sample_in,
    input  logic                                                sample_valid,
    output logic signed [OUT_W(DATA_WIDTH, COEFF_WIDTH)-1:0]    sample_out,
    output logic                                                sample_out_valid
);

    localparam int OW = OUT_W(DATA_WIDTH, COEFF_WIDTH);

    // A zero-tap filter has no meaning; stop elaboration instead of building nothing.
    if (TAPS < 1) begin : g_bad_taps
        $error("fir_filter: TAPS must be >= 1");
    end

    // x_q[0] is the most recent accepted sample, x_q[TAPS-1] the oldest.
    logic signed [DATA_WIDTH-1:0] x_q    [TAPS];
    logic signed [DATA_WIDTH-1:0] x_d    [TAPS];
    logic signed [DATA_WIDTH-1:0] tap_in [TAPS];
    logic signed [OW-1:0]         prod   [TAPS];
    logic signed [OW-1:0]         acc;
    logic signed [OW-1:0]         y_q;
    logic signed [OW-1:0]         y_d;
    logic                         vld_q;

    // Tap 0 sees the incoming sample directly; older taps see the delay line
    // as it stood before this edge, so the new sample is not counted twice.
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        if (k == 0) begin : g_newest
            assign tap_in[k] = sample_in;
        end else begin : g_history
            assign tap_in[k] = x_q[k-1];
        end

        fir_tap_mac #(
            .DATA_WIDTH  (DATA_WIDTH),
            .COEFF_WIDTH (COEFF_WIDTH),
            .COEFF       (COEFFS[k*COEFF_WIDTH +: COEFF_WIDTH])
        ) u_mac (
            .sample_i  (tap_in[k]),
            .product_o (prod[k])
        );
    end

    // Sum all tap products; beyond four taps the sum wraps at OW bits.
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + prod[k];
        end
    end

    // Next-state: shift and capture only on an accepted sample, else hold.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (sample_valid) begin
            y_d    = acc;
            x_d[0] = sample_in;
            for (int k = 1; k < TAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end
    end

    // State registers; reset wipes the history and the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
            y_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            vld_q <= sample_valid;
        end
    end

    assign sample_out       = y_q;
    assign sample_out_valid = vld_q;

endmodule

// File: tb/tb_fir_filter.sv
// Scoreboard bench for fir_filter: the driver queues hand-computed outputs,
// per-instance monitors pop and compare whenever an output is presented.
module tb_fir_filter;

    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int TAPS = 4;
    localparam int OW   = DW + CW + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic signed [DW-1:0] sample_in;
    logic                 sample_valid;
    logic signed [OW-1:0] sample_out;
    logic                 sample_out_valid;

    logic signed [DW-1:0] m_in;
    logic                 m_valid;
    logic signed [OW-1:0] m_out;
    logic                 m_out_valid;

    int vectors     = 0;
    int miscompares = 0;

    logic signed [OW-1:0] exp_q[$];
    logic signed [OW-1:0] exp_m_q[$];

    fir_filter #(
        .DATA_WIDTH  (DW),
        .COEFF_WIDTH (CW),
        .TAPS        (TAPS),
        .COEFFS      ({8'sd4, 8'sd3, 8'sd2, 8'sd1})
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid)
    );

    // All coefficients at -128 to exercise the largest possible magnitude.
    fir_filter #(
        .DATA_WIDTH  (DW),
        .COEFF_WIDTH (CW),
        .TAPS        (TAPS),
        .COEFFS      ({8'h80, 8'h80, 8'h80, 8'h80})
    ) dut_max (
        .clk              (clk),
        .rst              (rst),
        .sample_in        (m_in),
        .sample_valid     (m_valid),
        .sample_out       (m_out),
        .sample_out_valid (m_out_valid)
    );

    task automatic check(input string name, input logic signed [OW-1:0] act,
                         input logic signed [OW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Monitor for the default-coefficient instance.
    initial begin
        forever begin
            @(negedge clk);
            if (sample_out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out: got %0d, expected no output", sample_out);
                end else begin
                    check("y", sample_out, exp_q.pop_front());
                end
            end
        end
    end

    // Monitor for the max-magnitude instance.
    initial begin
        forever begin
            @(negedge clk);
            if (m_out_valid === 1'b1) begin
                if (exp_m_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_max_out: got %0d, expected no output", m_out);
                end else begin
                    check("y_max", m_out, exp_m_q.pop_front());
                end
            end
        end
    end

    task automatic send(input int x, input int y);
        @(negedge clk);
        sample_in    = DW'(x);
        sample_valid = 1'b1;
        exp_q.push_back(OW'(y));
    endtask

    task automatic send_max(input int x, input int y);
        @(negedge clk);
        m_in    = DW'(x);
        m_valid = 1'b1;
        exp_m_q.push_back(OW'(y));
    endtask

    // One idle cycle, then confirm the output holds and valid is low.
    task automatic idle_check(input string name, input int hold);
        @(negedge clk);
        sample_valid = 1'b0;
        sample_in    = 'x;
        @(negedge clk);
        check_bit({name, "_valid"}, sample_out_valid, 1'b0);
        check({name, "_hold"}, sample_out, OW'(hold));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        sample_valid = 1'b0;
        m_valid      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        m_in         = '0;
        m_valid      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out", sample_out, '0);
        check_bit("reset_valid", sample_out_valid, 1'b0);
        check("reset_max_out", m_out, '0);
        rst = 1'b0;

        // Ramp into an empty history.
        send(1, 1);
        send(2, 4);
        send(3, 10);
        send(4, 20);
        // Hold x=4 until the window is full of 4s.
        send(4, 29);
        send(4, 36);
        send(4, 40);
        send(4, 40);
        idle_check("after_ramp", 40);

        // Negative impulse walks through every coefficient.
        do_reset();
        send(-128, -128);
        send(0, -256);
        send(0, -384);
        send(0, -512);
        idle_check("after_impulse", -512);

        // Gaps must not shift the delay line.
        do_reset();
        send(1, 1);
        idle_check("gap1", 1);
        send(2, 4);
        idle_check("gap2", 4);

        // Reset mid-stream, with a valid sample offered during reset.
        do_reset();
        send(1, 1);
        send(2, 4);
        send(3, 10);
        @(negedge clk);
        rst          = 1'b1;
        sample_in    = DW'(7);
        sample_valid = 1'b1;
        @(negedge clk);
        check("midrst_out", sample_out, '0);
        check_bit("midrst_valid", sample_out_valid, 1'b0);
        @(negedge clk);
        check("midrst_out2", sample_out, '0);
        check_bit("midrst_valid2", sample_out_valid, 1'b0);
        rst          = 1'b0;
        sample_valid = 1'b0;
        send(5, 5);
        idle_check("after_midrst", 5);

        // Largest magnitude: every product is +16384.
        send_max(-128, 16384);
        send_max(-128, 32768);
        send_max(-128, 49152);
        send_max(-128, 65536);
        send_max(-128, 65536);
        @(negedge clk);
        m_valid = 1'b0;

        repeat (4) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_outputs: got %0d left, expected 0", exp_q.size());
        end
        vectors++;
        if (exp_m_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_max_outputs: got %0d left, expected 0", exp_m_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
